// File: rtl/adam_rst_seq_pkg.sv
// Shared types for the target reset sequencer.
// State enum is exported so benches can reuse it.
package adam_rst_seq_pkg;

  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_PAUSING,
    ST_PAUSED,
    ST_RST_HOLD,
    ST_RST_REL,
    ST_RESUMING
  } adam_rst_seq_state_t;

  typedef struct packed {
    logic tgt_rst;
    logic tgt_req;
    logic cfg_ack;
  } adam_rst_seq_out_t;

  localparam adam_rst_seq_out_t OUT_RST = '{
    tgt_rst: 1'b1,
    tgt_req: 1'b1,
    cfg_ack: 1'b0
  };

  // Output levels seen by target and syscfg in each state.
  function automatic adam_rst_seq_out_t
    adam_rst_seq_decode(adam_rst_seq_state_t s);
    adam_rst_seq_out_t o;
    o.tgt_rst = (s == ST_RST_HOLD);
    o.tgt_req = !((s == ST_RUN) ||
                  (s == ST_RESUMING));
    o.cfg_ack = (s == ST_PAUSED);
    return o;
  endfunction

endpackage

// File: rtl/adam_rst_seq.sv
// Reset sequencer between syscfg and one target.
// Pauses the target before reset, settles after.
import adam_rst_seq_pkg::*;

module adam_rst_seq #(
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned POST_RST_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT     = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic cfg_rst,
  input  logic cfg_pause_req,
  output logic cfg_pause_ack,
  output logic tgt_rst,
  output logic tgt_pause_req,
  input  logic tgt_pause_ack,
  input  logic err_clr,
  output logic err_timeout
);

  localparam logic [CNT_W-1:0] RST_LAST =
    16'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] POST_LAST =
    16'(POST_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST =
    16'(ACK_TIMEOUT - 1);

  adam_rst_seq_state_t state_q;
  adam_rst_seq_state_t state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [CNT_W-1:0]    cnt_inc;
  logic                err_set;
  logic                want;
  adam_rst_seq_out_t   out_d;
  adam_rst_seq_out_t   out_q;

  assign cnt_inc = cnt_q + 16'd1;
  assign want    = cfg_rst | cfg_pause_req;

  // State and counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RST_HOLD;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state, counter and timeout detection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_set = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (want) begin
          state_d = ST_PAUSING;
          cnt_d   = '0;
        end
      end
      ST_PAUSING: begin
        if (!tgt_pause_ack &&
            cnt_q == ACK_LAST)
          err_set = 1'b1;
        if (tgt_pause_ack) begin
          state_d = ST_PAUSED;
          cnt_d   = '0;
        end else if (!want) begin
          state_d = ST_RESUMING;
        end else if (cnt_q == ACK_LAST) begin
          // Stuck target: force reset if asked.
          if (cfg_rst) begin
            state_d = ST_RST_HOLD;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_PAUSED: begin
        if (cfg_rst) begin
          state_d = ST_RST_HOLD;
          cnt_d   = '0;
        end else if (!cfg_pause_req) begin
          state_d = ST_RESUMING;
        end
      end
      ST_RST_HOLD: begin
        if (cnt_q == RST_LAST) begin
          if (!cfg_rst) begin
            state_d = ST_RST_REL;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RST_REL: begin
        if (cfg_rst) begin
          state_d = ST_RST_HOLD;
          cnt_d   = '0;
        end else if (cnt_q == POST_LAST) begin
          state_d = ST_PAUSING;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_RESUMING: begin
        if (want) begin
          state_d = ST_PAUSING;
          cnt_d   = '0;
        end else if (!tgt_pause_ack) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RST_HOLD;
        cnt_d   = '0;
      end
    endcase
  end

  // Output levels for the upcoming state.
  always_comb begin
    out_d = adam_rst_seq_decode(state_d);
  end

  // Registered outputs track the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      out_q <= OUT_RST;
    else
      out_q <= out_d;
  end

  // Sticky timeout flag; a new set beats clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_timeout <= 1'b0;
    else if (err_set)
      err_timeout <= 1'b1;
    else if (err_clr)
      err_timeout <= 1'b0;
  end

  assign tgt_rst       = out_q.tgt_rst;
  assign tgt_pause_req = out_q.tgt_req;
  assign cfg_pause_ack = out_q.cfg_ack;

endmodule

// File: tb/tb_adam_rst_seq.sv
// Bench for adam_rst_seq: directed sequences
// plus random traffic against a reference model.
module tb_adam_rst_seq;

  localparam int RC = 16;
  localparam int PC = 4;
  localparam int TO = 256;

  logic clk = 1'b0;
  logic rst;
  logic cfg_rst;
  logic cfg_pause_req;
  logic cfg_pause_ack;
  logic tgt_rst;
  logic tgt_pause_req;
  logic tgt_pause_ack;
  logic err_clr;
  logic err_timeout;

  always #5 clk = ~clk;

  adam_rst_seq #(
    .RST_CYCLES     (RC),
    .POST_RST_CYCLES(PC),
    .ACK_TIMEOUT    (TO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_rst      (cfg_rst),
    .cfg_pause_req(cfg_pause_req),
    .cfg_pause_ack(cfg_pause_ack),
    .tgt_rst      (tgt_rst),
    .tgt_pause_req(tgt_pause_req),
    .tgt_pause_ack(tgt_pause_ack),
    .err_clr      (err_clr),
    .err_timeout  (err_timeout)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference phases of the sequence.
  localparam int RUN    = 0;
  localparam int PAUSE  = 1;
  localparam int HELD   = 2;
  localparam int HOLD   = 3;
  localparam int SETTLE = 4;
  localparam int RESUME = 5;

  int m_ph;
  int m_cnt;
  bit m_err;

  // Behavioural target.
  bit t_never;
  int t_dly;
  int t_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d",
               tag, got, exp);
    end
  endtask

  function automatic int sat(int v, int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic m_reset();
    m_ph  = HOLD;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic m_go(input int ph);
    m_ph  = ph;
    m_cnt = 0;
  endtask

  task automatic m_step();
    bit want;
    bit timeout;
    want    = cfg_rst || cfg_pause_req;
    timeout = 1'b0;
    case (m_ph)
      RUN:
        if (want) m_go(PAUSE);
      PAUSE: begin
        timeout = !tgt_pause_ack && (m_cnt == TO - 1);
        if (tgt_pause_ack) m_go(HELD);
        else if (!want) m_ph = RESUME;
        else if (timeout && cfg_rst) m_go(HOLD);
        else m_cnt = sat(m_cnt + 1, TO - 1);
      end
      HELD:
        if (cfg_rst) m_go(HOLD);
        else if (!cfg_pause_req) m_ph = RESUME;
      HOLD:
        if (m_cnt == RC - 1 && !cfg_rst) m_go(SETTLE);
        else m_cnt = sat(m_cnt + 1, RC - 1);
      SETTLE:
        if (cfg_rst) m_go(HOLD);
        else if (m_cnt == PC - 1) m_go(PAUSE);
        else m_cnt++;
      RESUME:
        if (want) m_go(PAUSE);
        else if (!tgt_pause_ack) m_ph = RUN;
      default: m_reset();
    endcase
    m_err = timeout || (m_err && !err_clr);
  endtask

  task automatic compare();
    chk("tgt_rst", tgt_rst, m_ph == HOLD);
    chk("tgt_req", tgt_pause_req,
        !(m_ph == RUN || m_ph == RESUME));
    chk("cfg_ack", cfg_pause_ack, m_ph == HELD);
    chk("err", err_timeout, m_err);
    chk("rst_no_req", tgt_rst & ~tgt_pause_req, 0);
  endtask

  task automatic target();
    if (t_never) begin
      tgt_pause_ack = 1'b0;
      t_cnt = 0;
    end else if (tgt_pause_req != tgt_pause_ack) begin
      if (t_cnt >= t_dly) begin
        tgt_pause_ack = tgt_pause_req;
        t_cnt = 0;
      end else begin
        t_cnt++;
      end
    end else begin
      t_cnt = 0;
    end
  endtask

  // One clock: model steps on the edge, check at negedge.
  task automatic tick();
    @(posedge clk);
    if (rst) m_reset();
    else m_step();
    @(negedge clk);
    compare();
    target();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("arst_tgt_rst", tgt_rst, 1);
    chk("arst_tgt_req", tgt_pause_req, 1);
    chk("arst_cfg_ack", cfg_pause_ack, 0);
    chk("arst_err", err_timeout, 0);
    m_reset();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic wait_run();
    int n;
    cfg_rst = 1'b0;
    cfg_pause_req = 1'b0;
    t_never = 1'b0;
    n = 0;
    while ((tgt_pause_req || tgt_rst) && n < 2000) begin
      tick();
      n++;
    end
    chk("reach_run", tgt_pause_req | tgt_rst, 0);
    repeat (8) tick();
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cfg_rst = 1'b0;
    cfg_pause_req = 1'b0;
    tgt_pause_ack = 1'b0;
    err_clr = 1'b0;
    t_never = 1'b0;
    t_dly = 2;
    t_cnt = 0;
    m_reset();
    repeat (3) @(negedge clk);
    chk("rst_tgt_rst", tgt_rst, 1);
    chk("rst_tgt_req", tgt_pause_req, 1);
    chk("rst_cfg_ack", cfg_pause_ack, 0);
    chk("rst_err", err_timeout, 0);
    rst = 1'b0;

    // Full hold after power-on reset.
    n = 0;
    while (tgt_rst && n < 1000) begin
      tick();
      n++;
    end
    chk("rst_len", n, RC);
    wait_run();

    // Pause handshake through syscfg.
    t_dly = 3;
    cfg_pause_req = 1'b1;
    n = 0;
    while (!cfg_pause_ack && n < 100) begin
      tick();
      n++;
    end
    chk("pause_ack", cfg_pause_ack, 1);
    repeat (3) tick();
    cfg_pause_req = 1'b0;
    tick();
    chk("ack_drop", cfg_pause_ack, 0);
    chk("req_drop", tgt_pause_req, 0);
    wait_run();

    // Requested reset: fixed-length hold.
    t_dly = 0;
    cfg_rst = 1'b1;
    n = 0;
    while (!tgt_rst && n < 100) begin
      tick();
      n++;
    end
    cfg_rst = 1'b0;
    n = 0;
    while (tgt_rst && n < 1000) begin
      n++;
      tick();
    end
    chk("req_rst_len", n, RC);
    wait_run();

    // Target never acks: timeout forces reset.
    t_never = 1'b1;
    cfg_rst = 1'b1;
    err_clr = 1'b1;
    tick();
    n = 0;
    while (!err_timeout && n < 1000) begin
      n++;
      tick();
    end
    chk("timeout_len", n, TO);
    chk("forced_rst", tgt_rst, 1);
    err_clr = 1'b0;

    // Long cfg_rst keeps target in reset.
    repeat (100) tick();
    chk("long_hold", tgt_rst, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("err_cleared", err_timeout, 0);
    cfg_rst = 1'b0;
    n = 0;
    while (tgt_rst && n < 1000) begin
      tick();
      n++;
    end
    tick();
    do_reset();
    wait_run();

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0)
        cfg_rst = ~cfg_rst;
      if ($urandom_range(0, 9) == 0)
        cfg_pause_req = ~cfg_pause_req;
      err_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 199) == 0)
        t_never = ~t_never;
      if ($urandom_range(0, 49) == 0)
        t_dly = $urandom_range(0, 4);
      if ($urandom_range(0, 799) == 0)
        do_reset();
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
